// File: rtl/vga_ball_renderer.sv
// Bouncing-ball pixel source feeding the VGA timing stage; RGB is registered, one cycle behind hcount/vcount.
// Define VGA_BALL_BORDER_EN to draw a 3-pixel green frame just inside the visible window.
module vga_ball_renderer #(
    parameter int H_MIN = 144,
    parameter int H_MAX = 784,
    parameter int V_MIN = 35,
    parameter int V_MAX = 515,
    parameter int SIZE  = 16,
    parameter int STEP  = 2,
    parameter int X0    = 456,
    parameter int Y0    = 267
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       frame_tick,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       pause_btn,
    output logic [3:0] r_o,
    output logic [3:0] g_o,
    output logic [3:0] b_o,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [7:0] bounce_cnt
);

    localparam logic [10:0] X_LO   = 11'(H_MIN);
    localparam logic [10:0] X_HI   = 11'(H_MAX - SIZE);
    localparam logic [10:0] Y_LO   = 11'(V_MIN);
    localparam logic [10:0] Y_HI   = 11'(V_MAX - SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] SIZE_W = 11'(SIZE);
    localparam logic [9:0]  STEP_N = 10'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        PAUSED
    } state_t;

    state_t      state_q, state_d;
    logic        pauseMeta_q, pauseSync_q;
    logic [9:0]  ballX_q, ballX_d, ballY_q, ballY_d;
    logic        dirX_q, dirX_d, dirY_q, dirY_d;
    logic [7:0]  bounceCnt_q, bounceCnt_d;
    logic [11:0] rgb_q, rgb_d;
    logic        doMove, bounceX, bounceY;
    logic [9:0]  stepX, stepY;
    logic [10:0] xW, yW, hW, vW;
    logic        insideBall;

    assign xW = {1'b0, ballX_q};
    assign yW = {1'b0, ballY_q};
    assign hW = {1'b0, hcount};
    assign vW = {1'b0, vcount};

    // The push-button is asynchronous to the pixel clock, so it is double-flopped before the FSM sees it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pauseMeta_q <= 1'b0;
            pauseSync_q <= 1'b0;
        end else begin
            pauseMeta_q <= pause_btn;
            pauseSync_q <= pauseMeta_q;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            ballX_q     <= 10'(X0);
            ballY_q     <= 10'(Y0);
            dirX_q      <= 1'b1;
            dirY_q      <= 1'b1;
            bounceCnt_q <= 8'd0;
            rgb_q       <= 12'h000;
        end else begin
            state_q     <= state_d;
            ballX_q     <= ballX_d;
            ballY_q     <= ballY_d;
            dirX_q      <= dirX_d;
            dirY_q      <= dirY_d;
            bounceCnt_q <= bounceCnt_d;
            rgb_q       <= rgb_d;
        end
    end

    // Every transition happens on a frame tick; only a tick seen in MOVE with pause released moves the ball.
    always_comb begin
        state_d = state_q;
        doMove  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick) state_d = MOVE;
            end
            MOVE: begin
                if (frame_tick) begin
                    if (pauseSync_q) state_d = PAUSED;
                    else             doMove  = 1'b1;
                end
            end
            PAUSED: begin
                if (frame_tick && !pauseSync_q) state_d = MOVE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Limit tests use 11 bits so ball+STEP cannot wrap; a step that would overshoot clamps to the limit and flips direction.
    always_comb begin
        bounceX = 1'b0;
        bounceY = 1'b0;
        if (dirX_q) begin
            if (xW + STEP_W > X_HI) begin
                stepX   = X_HI[9:0];
                bounceX = 1'b1;
            end else begin
                stepX = ballX_q + STEP_N;
            end
        end else if (xW < X_LO + STEP_W) begin
            stepX   = X_LO[9:0];
            bounceX = 1'b1;
        end else begin
            stepX = ballX_q - STEP_N;
        end

        if (dirY_q) begin
            if (yW + STEP_W > Y_HI) begin
                stepY   = Y_HI[9:0];
                bounceY = 1'b1;
            end else begin
                stepY = ballY_q + STEP_N;
            end
        end else if (yW < Y_LO + STEP_W) begin
            stepY   = Y_LO[9:0];
            bounceY = 1'b1;
        end else begin
            stepY = ballY_q - STEP_N;
        end

        ballX_d     = doMove ? stepX : ballX_q;
        ballY_d     = doMove ? stepY : ballY_q;
        dirX_d      = (doMove && bounceX) ? ~dirX_q : dirX_q;
        dirY_d      = (doMove && bounceY) ? ~dirY_q : dirY_q;
        bounceCnt_d = bounceCnt_q;
        if (doMove && (bounceX || bounceY) && (bounceCnt_q != 8'hFF))
            bounceCnt_d = bounceCnt_q + 8'd1;
    end

    assign insideBall = (hW >= xW) && (hW < xW + SIZE_W) &&
                        (vW >= yW) && (vW < yW + SIZE_W);

`ifdef VGA_BALL_BORDER_EN
    localparam logic [10:0] H_END = 11'(H_MAX);
    localparam logic [10:0] V_END = 11'(V_MAX);

    logic inWindow, onBorder;

    // The ball is drawn over the border where they overlap.
    always_comb begin
        inWindow = (hW >= X_LO) && (hW < H_END) && (vW >= Y_LO) && (vW < V_END);
        onBorder = inWindow && ((hW < X_LO + 11'd3) || (hW >= H_END - 11'd3) ||
                                (vW < Y_LO + 11'd3) || (vW >= V_END - 11'd3));
        rgb_d = 12'h000;
        if (insideBall)    rgb_d = 12'hFFF;
        else if (onBorder) rgb_d = 12'h0F0;
    end
`else
    always_comb begin
        rgb_d = insideBall ? 12'hFFF : 12'h000;
    end
`endif

    assign r_o        = rgb_q[11:8];
    assign g_o        = rgb_q[7:4];
    assign b_o        = rgb_q[3:0];
    assign ball_x     = ballX_q;
    assign ball_y     = ballY_q;
    assign bounce_cnt = bounceCnt_q;

endmodule

// File: doc/vga_ball_renderer.md
Name: vga_ball_renderer

Overview:
- Pixel-source stage directly upstream of the VGA timing/output stage.
- Takes that stage's raw 800x525 scan counters and a once-per-frame tick.
- Keeps a square ball that moves by a fixed step each frame and bounces off the edges of the visible window.
- Returns registered 4-bit RGB for the current scan position, which the timing stage blanks outside the active window.

Parameters:
- H_MIN, 144, first visible hcount
- H_MAX, 784, visible hcount upper bound (exclusive)
- V_MIN, 35, first visible vcount
- V_MAX, 515, visible vcount upper bound (exclusive)
- SIZE, 16, ball edge length in pixels
- STEP, 2, pixels moved per frame on each axis
- X0, 456, reset ball left edge
- Y0, 267, reset ball top edge

Ports:
- clk  in  1  pixel clock (25 MHz)
- clr  in  1  reset; asynchronous, active-high
- frame_tick  in  1  one-cycle pulse, once per frame, asserted during vertical blank
- hcount  in  10  raw horizontal scan counter, 0..799
- vcount  in  10  raw vertical scan counter, 0..524
- pause_btn  in  1  asynchronous pause level from a push-button
- r_o  out  4  red pixel value
- g_o  out  4  green pixel value
- b_o  out  4  blue pixel value
- ball_x  out  10  ball left edge, in hcount units
- ball_y  out  10  ball top edge, in vcount units
- bounce_cnt  out  8  saturating count of bounce events

Behaviour:
- Reset (async, clr=1):
  - ball_x=X0, ball_y=Y0; direction dx=+1, dy=+1.
  - bounce_cnt=0; r_o/g_o/b_o=0.
  - Pause synchronizer flops=0; state=IDLE.
- pause_btn passes through a 2-flop synchronizer to give pause_s, which is 2 cycles late.
- FSM:
  - IDLE: on frame_tick go to MOVE; no position update on that tick.
  - MOVE: on frame_tick with pause_s=1, go to PAUSED with no update. On frame_tick with pause_s=0, update the position.
  - PAUSED: on frame_tick with pause_s=0, go to MOVE with no update that tick. Otherwise hold.
- Position updates happen only on frame_tick cycles, so the ball never tears mid-frame.
- X update (Y is identical, using V_MIN/V_MAX):
  - dx=+1: if ball_x+STEP > H_MAX-SIZE, then ball_x<=H_MAX-SIZE and dx<=-1 (a bounce). Else ball_x<=ball_x+STEP.
  - dx=-1: if ball_x < H_MIN+STEP, then ball_x<=H_MIN and dx<=+1 (a bounce). Else ball_x<=ball_x-STEP.
- Arithmetic is done at 11 bits to avoid wrap; results always lie within [MIN, MAX-SIZE].
- bounce_cnt:
  - +1 per tick where any axis bounced; a corner hit, with both axes bouncing on the same tick, counts once.
  - Saturates at 255.
- Pixel path, 1-cycle latency:
  - Registered output reflects the hcount/vcount presented on the previous cycle.
  - inside = hcount in [ball_x, ball_x+SIZE) and vcount in [ball_y, ball_y+SIZE).
  - inside: RGB=F,F,F. Otherwise RGB=0,0,0.
  - Uses the ball_x/ball_y current at that cycle.
- No blanking is applied here; blanking is the downstream stage's job.
- frame_tick arriving together with clr: reset wins.
- hcount/vcount outside the visible window: the pixel is rendered by the rule above, and the downstream stage blanks it.

Optional Feature:
- Macro: VGA_BALL_BORDER_EN.
- Defined: a 3-pixel frame inside the visible window is drawn with RGB=0,F,0 (green). The frame covers hcount in [H_MIN,H_MIN+3) or [H_MAX-3,H_MAX), and vcount in [V_MIN,V_MIN+3) or [V_MAX-3,V_MAX), within the window. The ball has priority over the border. Bounce limits are unchanged.
- Undefined: no border; the background is all 0.

Test Plan:
- Reset then pixel probe: clr pulse, hcount=456, vcount=267 -> next cycle RGB=F,F,F. hcount=472 -> 0,0,0. ball_x=456, ball_y=267, bounce_cnt=0.
- Startup and motion: first frame_tick -> position unchanged. Next 3 ticks -> ball_x=462, ball_y=273.
- Right bounce (X0=765): ticks give ball_x 767 -> 768 (clamped), with dx flipped and bounce_cnt=1. Next tick -> ball_x=766.
- Corner bounce (X0=767, Y0=498, SIZE=16): one move tick -> ball_x=768, ball_y=499, both directions flip, bounce_cnt=1 (not 2).
- Pause: hold pause_btn=1 for more than 3 cycles before a tick -> ball frozen across 5 ticks. Release -> the first tick only re-enters MOVE, the second tick moves by STEP.
- Async reset mid-frame: clr asserted between clock edges while in MOVE at ball_x=600 -> outputs return to reset values immediately, without waiting for a clock edge. With VGA_BALL_BORDER_EN defined, pixel (145,300) -> RGB=0,F,0.
